instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/riscv_pkg.sv | 22 ++
 rtl/instr_fetch_if.sv | 27 ++
 rtl/instr_fetch_pc_next_sel.sv | 17 +
 rtl/instr_fetch.sv | 111 +++++++++++
 tb/tb_instr_fetch.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/riscv_pkg.sv
// Shared fetch-stage types and RV32I constants: fetch FSM states, major opcodes, NOP encoding.
package riscv_pkg;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned OP_W    = 7;

    localparam logic [OP_W-1:0] OP_LOAD   = 7'b0000011;
    localparam logic [OP_W-1:0] OP_STORE  = 7'b0100011;
    localparam logic [OP_W-1:0] OP_RTYPE  = 7'b0110011;
    localparam logic [OP_W-1:0] OP_BRANCH = 7'b1100011;

    // addi x0, x0, 0
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/instr_fetch_if.sv
// Instruction-memory request/response bus between the fetch stage (master) and imem (slave).
interface instr_fetch_if;
    import riscv_pkg::*;

    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_addr;
    logic            imem_rsp_valid;
    logic [XLEN-1:0] imem_rdata;

    modport master (
        output imem_req_valid,
        output imem_addr,
        input  imem_req_ready,
        input  imem_rsp_valid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req_valid,
        input  imem_addr,
        output imem_req_ready,
        output imem_rsp_valid,
        output imem_rdata
    );

endinterface

// File: rtl/instr_fetch_pc_next_sel.sv
// Next-PC mux: sequential pc+4 (wrapping modulo 2^32) or the taken-branch target.
module pc_next_sel
    import riscv_pkg::*;
(
    input  logic [XLEN-1:0] pc,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] branch_target,
    output logic [XLEN-1:0] next_pc,
    output logic [XLEN-1:0] pc_plus4
);

    always_comb begin
        pc_plus4 = pc + XLEN'(4);
        next_pc  = branch_taken ? branch_target : pc_plus4;
    end

endmodule

// File: rtl/instr_fetch.sv
// Single-outstanding instruction fetch stage: IDLE -> REQ -> WAIT -> HOLD, one word held for decode.
// Optional FETCH_MISALIGN_CHECK_EN adds a sticky misalign flag that blocks misaligned taken branches.
module instr_fetch
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
)(
    input  logic             clk,
    input  logic             rst_n,
    instr_fetch_if.master    imem,
    output logic             instr_valid,
    output logic [XLEN-1:0]  instr,
    output logic [OP_W-1:0]  op,
    output logic [XLEN-1:0]  pc,
    output logic [XLEN-1:0]  pc_plus4,
    input  logic             advance,
    input  logic             branch_taken,
    input  logic [XLEN-1:0]  branch_target
`ifdef FETCH_MISALIGN_CHECK_EN
    ,
    output logic             misalign
`endif
);

    fetch_state_t    state;
    fetch_state_t    state_nxt;
    logic [XLEN-1:0] next_pc;
    logic            bad_target;
    logic            pc_load;
    logic            rsp_take;

    pc_next_sel u_pc_next_sel (
        .pc            (pc),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .next_pc       (next_pc),
        .pc_plus4      (pc_plus4)
    );

`ifdef FETCH_MISALIGN_CHECK_EN
    assign bad_target = branch_taken & (branch_target[1:0] != 2'b00);
`else
    assign bad_target = 1'b0;
`endif

    // Retire/redirect happens only from HOLD; a misaligned target keeps the word held.
    assign pc_load  = (state == HOLD) & advance & ~bad_target;
    assign rsp_take = (state == WAIT) & imem.imem_rsp_valid;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: state_nxt = REQ;
            REQ:  if (imem.imem_req_ready) state_nxt = WAIT;
            WAIT: if (imem.imem_rsp_valid) state_nxt = HOLD;
            HOLD: if (pc_load)             state_nxt = REQ;
            default: state_nxt = IDLE;
        endcase
    end

    // Moore outputs decoded from the state register
    always_comb begin
        imem.imem_req_valid = 1'b0;
        instr_valid         = 1'b0;
        case (state)
            REQ:     imem.imem_req_valid = 1'b1;
            HOLD:    instr_valid         = 1'b1;
            default: ;
        endcase
    end

    // PC and instruction holding registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc    <= RESET_PC;
            instr <= NOP_INSTR;
        end else begin
            if (pc_load) begin
                pc <= next_pc;
            end
            if (rsp_take) begin
                instr <= imem.imem_rdata;
            end
        end
    end

`ifdef FETCH_MISALIGN_CHECK_EN
    // Sticky until reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            misalign <= 1'b0;
        end else if ((state == HOLD) && advance && bad_target) begin
            misalign <= 1'b1;
        end
    end
`endif

    assign imem.imem_addr = pc;
    assign op             = instr[OP_W-1:0];

endmodule

// File: tb/tb_instr_fetch.sv
// Directed table-driven bench for instr_fetch plus hand-written reset-abort and misalign sequences.
module tb_instr_fetch;

    logic        clk;
    logic        rst_n;
    logic        instr_valid;
    logic [31:0] instr;
    logic [6:0]  op;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        advance;
    logic        branch_taken;
    logic [31:0] branch_target;
`ifdef FETCH_MISALIGN_CHECK_EN
    logic        misalign;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    instr_fetch_if imem_bus ();

    instr_fetch #(.RESET_PC(32'h0000_0000)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem          (imem_bus),
        .instr_valid   (instr_valid),
        .instr         (instr),
        .op            (op),
        .pc            (pc),
        .pc_plus4      (pc_plus4),
        .advance       (advance),
        .branch_taken  (branch_taken),
        .branch_target (branch_target)
`ifdef FETCH_MISALIGN_CHECK_EN
        ,
        .misalign      (misalign)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        ready;
        logic        rsp;
        logic [31:0] rdata;
        logic        adv;
        logic        bt;
        logic [31:0] target;
        logic        exp_rv;
        logic        exp_iv;
        logic [31:0] exp_pc;
        logic [31:0] exp_instr;
    } vec_t;

    localparam int NVEC = 25;
    vec_t vecs [NVEC];

    function automatic vec_t mk(input logic ready, input logic rsp, input logic [31:0] rdata,
                                input logic adv, input logic bt, input logic [31:0] target,
                                input logic exp_rv, input logic exp_iv,
                                input logic [31:0] exp_pc, input logic [31:0] exp_instr);
        vec_t v;
        v.ready = ready; v.rsp = rsp; v.rdata = rdata;
        v.adv = adv; v.bt = bt; v.target = target;
        v.exp_rv = exp_rv; v.exp_iv = exp_iv; v.exp_pc = exp_pc; v.exp_instr = exp_instr;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got %h, want %h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input logic ready, input logic rsp, input logic [31:0] rdata,
                         input logic adv, input logic bt, input logic [31:0] target);
        imem_bus.imem_req_ready = ready;
        imem_bus.imem_rsp_valid = rsp;
        imem_bus.imem_rdata     = rdata;
        advance                 = adv;
        branch_taken            = bt;
        branch_target           = target;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input int idx, input logic rv, input logic iv,
                           input logic [31:0] epc, input logic [31:0] ein);
        logic [31:0] epc4;
        logic [31:0] eop;
        epc4 = epc + 32'd4;
        eop  = {25'd0, ein[6:0]};
        chk({tag, ".req_valid"},   idx, {31'd0, imem_bus.imem_req_valid}, {31'd0, rv});
        chk({tag, ".instr_valid"}, idx, {31'd0, instr_valid},             {31'd0, iv});
        chk({tag, ".pc"},          idx, pc,                               epc);
        chk({tag, ".imem_addr"},   idx, imem_bus.imem_addr,               epc);
        chk({tag, ".pc_plus4"},    idx, pc_plus4,                         epc4);
        chk({tag, ".instr"},       idx, instr,                            ein);
        chk({tag, ".op"},          idx, {25'd0, op},                      eop);
    endtask

    initial begin
        //              rdy rsp rdata          adv bt target         rv iv pc             instr
        vecs[0]  = mk(1, 0, 32'h0,          0, 0, 32'h0,          1, 0, 32'h0,          32'h0000_0013);
        vecs[1]  = mk(1, 1, 32'hDEAD_BEEF,  0, 0, 32'h0,          0, 0, 32'h0,          32'h0000_0013);
        vecs[2]  = mk(0, 1, 32'h0000_2083,  0, 0, 32'h0,          0, 1, 32'h0,          32'h0000_2083);
        vecs[3]  = mk(0, 1, 32'h0000_1111,  0, 0, 32'h0,          0, 1, 32'h0,          32'h0000_2083);
        vecs[4]  = mk(0, 0, 32'h0,          1, 0, 32'h0,          1, 0, 32'h4,          32'h0000_2083);
        vecs[5]  = mk(0, 0, 32'h0,          1, 1, 32'h80,         1, 0, 32'h4,          32'h0000_2083);
        vecs[6]  = mk(0, 1, 32'h5555_5555,  1, 1, 32'h80,         1, 0, 32'h4,          32'h0000_2083);
        vecs[7]  = mk(0, 0, 32'h0,          0, 0, 32'h0,          1, 0, 32'h4,          32'h0000_2083);
        vecs[8]  = mk(1, 0, 32'h0,          0, 0, 32'h0,          0, 0, 32'h4,          32'h0000_2083);
        vecs[9]  = mk(0, 0, 32'h0,          1, 0, 32'h0,          0, 0, 32'h4,          32'h0000_2083);
        vecs[10] = mk(0, 1, 32'h0000_0033,  0, 0, 32'h0,          0, 1, 32'h4,          32'h0000_0033);
        vecs[11] = mk(0, 0, 32'h0,          1, 1, 32'h10,         1, 0, 32'h10,         32'h0000_0033);
        vecs[12] = mk(1, 0, 32'h0,          0, 0, 32'h0,          0, 0, 32'h10,         32'h0000_0033);
        vecs[13] = mk(0, 1, 32'h0020_8063,  0, 0, 32'h0,          0, 1, 32'h10,         32'h0020_8063);
        vecs[14] = mk(0, 0, 32'h0,          1, 1, 32'h40,         1, 0, 32'h40,         32'h0020_8063);
        vecs[15] = mk(1, 0, 32'h0,          0, 0, 32'h0,          0, 0, 32'h40,         32'h0020_8063);
        vecs[16] = mk(0, 1, 32'h0020_2023,  0, 0, 32'h0,          0, 1, 32'h40,         32'h0020_2023);
        vecs[17] = mk(0, 0, 32'h0,          1, 1, 32'hFFFF_FFFC,  1, 0, 32'hFFFF_FFFC,  32'h0020_2023);
        vecs[18] = mk(1, 0, 32'h0,          0, 0, 32'h0,          0, 0, 32'hFFFF_FFFC,  32'h0020_2023);
        vecs[19] = mk(0, 1, 32'h0000_0013,  0, 0, 32'h0,          0, 1, 32'hFFFF_FFFC,  32'h0000_0013);
        vecs[20] = mk(0, 0, 32'h0,          1, 0, 32'h0,          1, 0, 32'h0,          32'h0000_0013);
        vecs[21] = mk(1, 0, 32'h0,          0, 0, 32'h0,          0, 0, 32'h0,          32'h0000_0013);
        vecs[22] = mk(0, 1, 32'h0000_0013,  0, 0, 32'h0,          0, 1, 32'h0,          32'h0000_0013);
        vecs[23] = mk(0, 0, 32'h0,          1, 0, 32'h0,          1, 0, 32'h4,          32'h0000_0013);
        vecs[24] = mk(1, 0, 32'h0,          0, 0, 32'h0,          0, 0, 32'h4,          32'h0000_0013);

        rst_n = 1'b0;
        drive(0, 0, 32'h0, 0, 0, 32'h0);
        tick();
        tick();
        chk_all("reset", 0, 1'b0, 1'b0, 32'h0, 32'h0000_0013);
`ifdef FETCH_MISALIGN_CHECK_EN
        chk("reset.misalign", 0, {31'd0, misalign}, 32'd0);
`endif
        rst_n = 1'b1;

        // Table: outputs checked after the edge that consumes each vector's inputs
        for (int i = 0; i < NVEC; i++) begin
            drive(vecs[i].ready, vecs[i].rsp, vecs[i].rdata, vecs[i].adv, vecs[i].bt, vecs[i].target);
            tick();
            chk_all("vec", i, vecs[i].exp_rv, vecs[i].exp_iv, vecs[i].exp_pc, vecs[i].exp_instr);
        end

        // Reset while a fetch is outstanding in WAIT at pc=4
        drive(0, 0, 32'h0, 0, 0, 32'h0);
        rst_n = 1'b0;
        #1;
        chk_all("rst_wait", 0, 1'b0, 1'b0, 32'h0, 32'h0000_0013);
        tick();
        rst_n = 1'b1;
        // Late response lands during IDLE, then during REQ: both ignored
        drive(0, 1, 32'h0BAD_0BAD, 0, 0, 32'h0);
        tick();
        chk_all("rst_late", 0, 1'b1, 1'b0, 32'h0, 32'h0000_0013);
        tick();
        chk_all("rst_late", 1, 1'b1, 1'b0, 32'h0, 32'h0000_0013);
        drive(1, 0, 32'h0, 0, 0, 32'h0);
        tick();
        chk_all("rst_refetch", 0, 1'b0, 1'b0, 32'h0, 32'h0000_0013);
        drive(0, 1, 32'h0000_2083, 0, 0, 32'h0);
        tick();
        chk_all("rst_refetch", 1, 1'b0, 1'b1, 32'h0, 32'h0000_2083);

        // Taken branch to a misaligned target from HOLD at pc=0
        drive(0, 0, 32'h0, 1, 1, 32'h42);
        tick();
`ifdef FETCH_MISALIGN_CHECK_EN
        chk_all("misalign", 0, 1'b0, 1'b1, 32'h0, 32'h0000_2083);
        chk("misalign.flag", 0, {31'd0, misalign}, 32'd1);
        drive(0, 0, 32'h0, 0, 0, 32'h0);
        tick();
        chk_all("misalign", 1, 1'b0, 1'b1, 32'h0, 32'h0000_2083);
        chk("misalign.flag", 1, {31'd0, misalign}, 32'd1);
`else
        chk_all("unchecked", 0, 1'b1, 1'b0, 32'h42, 32'h0000_2083);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
